spi_config_sequencer: RTL and testbench
=======================================

Name: spi_config_sequencer

Overview:
On-chip SPI host that programs the SPI peripheral's five configuration registers (addresses 0-4: output enables, PWM enables, PWM duty cycle). On a start pulse it latches a 40-bit config image and a write mask, then issues one 16-bit write frame per selected register, in ascending address order, on ncs/sclk/copi. It sequences the peripheral's register writes so that bring-up logic and test firmware never bit-bang SPI.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles; must be at least 4 to clear the peripheral's 2-FF input synchronisers (elaboration error below 4)
NUM_REGS, 5, number of addressable registers; frames go to addresses 0..NUM_REGS-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to run a sequence; ignored while busy=1
wr_mask  input  NUM_REGS  bit i=1 writes register i; latched on accepted start
cfg_data  input  8*NUM_REGS  byte i = cfg_data[8i+7:8i] = data for address i; latched on accepted start
ncs  output  1  SPI chip select, active low
sclk  output  1  SPI clock, idle low
copi  output  1  SPI serial data to peripheral
busy  output  1  high from the cycle after an accepted start through the done cycle
done  output  1  one-cycle pulse when the sequence completes
cur_addr  output  3  address of the frame in progress; holds the last address after done

Behaviour:
- Reset (synchronous, any state): next cycle ncs=1, sclk=0, copi=0, busy=0, done=0, cur_addr=0; FSM to IDLE. Any frame in flight is abandoned with no further sclk edges.
- Every output is registered. start is accepted only in IDLE. cfg_data and wr_mask are sampled on the accepted-start edge, and later changes have no effect until the next start.
- Frame format: 16 bits, driven in this order: bit0 = R/W = 1 (write); bits 1-7 = address[0]..address[6] (LSB first); bits 8-15 = data[0]..data[7] (LSB first).
- SPI mode 0: the peripheral samples on sclk rise. copi changes only while sclk is low, on the cycle sclk falls, or in SETUP.
- States and durations (D = CLK_DIV):
  - IDLE: outputs idle. On start with wr_mask != 0, go to FLUSH_HI.
  - FLUSH_HI (D cycles), then FLUSH_LO (D cycles): one sclk pulse with ncs=1. This realigns the peripheral's bit counter.
  - SELECT (1 cycle): pick the lowest remaining mask bit, load the 16-bit shift register, update cur_addr, and clear that mask bit.
  - SETUP (D cycles): ncs=0, sclk=0, copi=bit0.
  - SCK_HI (D cycles): sclk=1.
  - SCK_LO (D cycles): sclk=0, copi shifts to the next bit. After the 16th SCK_HI, go to HOLD instead.
  - HOLD (D cycles): ncs=0, sclk=0.
  - GAP (2D cycles): ncs=1. Then go to SELECT if mask bits remain, else DONE.
  - DONE (1 cycle): done=1, then IDLE.
- Per frame: exactly 16 sclk rising edges. ncs low for 34*D cycles. ncs rises only after sclk has been low for D cycles.
- start with wr_mask=0: busy=1 for one cycle, then DONE. No ncs or sclk activity and no flush pulse.
- Half-period counter is ceil(log2(D+1)) bits. The bit counter is 4 bits, and the terminal bit count is 15.
- Mask bits at or above NUM_REGS do not exist. The address field's upper bits are zero.

Test Plan:
- Single write, rst then start, wr_mask=00001, byte0=0xA5, D=4:
  - One flush pulse with ncs=1.
  - copi at the 16 sclk rises = 1,0,0,0,0,0,0,0,1,0,1,0,0,1,0,1.
  - ncs low for exactly 136 cycles.
  - done one cycle after GAP.
  - Attached peripheral model shows en_reg_out_7_0=0xA5.
- Multi-write, wr_mask=10100, byte2=0x3C, byte4=0x80:
  - Two frames, cur_addr 2 then 4, with ncs high for 8 cycles between them.
  - Peripheral model ends with pwm_duty_cycle=0x80.
  - Exactly 32 data sclk rises plus 1 flush rise.
- wr_mask=0: busy high for 1 cycle, done the next cycle; ncs stays 1 and sclk stays 0 throughout.
- Start while busy, plus cfg_data changed mid-sequence: the second start is ignored, and the frame bits match the originally latched bytes.
- rst asserted during SCK_HI of bit 9:
  - Next cycle ncs=1, sclk=0, copi=0, busy=0.
  - A fresh start then issues a flush pulse and a correct frame, and the peripheral model captures the new byte.
- D=8, single write: sclk high and low phases each 8 cycles, ncs low for 272 cycles; copi never changes while sclk=1.

Source files
------------

// File: rtl/spi_config_sequencer.sv
// SPI configuration sequencer: on a start pulse, latches a register image and a
// write mask, then issues one 16-bit SPI mode-0 write frame per selected
// register in ascending address order. Every output comes straight from a flop.
//
// Frame timing (D = CLK_DIV):
//   SETUP D, then 16 x (SCK_HI D, SCK_LO D), then HOLD D gives 34*D cycles of ncs
//   low, with 16 sclk rises. The final SCK_LO plus HOLD keeps sclk low for 2*D
//   cycles before ncs rises.
//   Between frames, the GAP second half is shortened by one cycle so that GAP plus
//   SELECT keeps ncs high for exactly 2*D cycles. After the last frame, GAP runs
//   its full 2*D cycles and DONE follows directly.
module spi_config_sequencer #(
  parameter int CLK_DIV  = 4,
  parameter int NUM_REGS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_REGS-1:0]   wr_mask,
  input  logic [8*NUM_REGS-1:0] cfg_data,
  output logic                  ncs,
  output logic                  sclk,
  output logic                  copi,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            cur_addr
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] HALF_LAST      = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_SHORT_LAST = CW'(CLK_DIV - 2);

  // The peripheral's 2-FF synchronisers need at least four clk cycles per sclk phase.
  generate
    if (CLK_DIV < 4) begin : g_bad_clk_div
      $error("spi_config_sequencer: CLK_DIV must be at least 4");
    end
    if (NUM_REGS < 1 || NUM_REGS > 8) begin : g_bad_num_regs
      $error("spi_config_sequencer: NUM_REGS must be between 1 and 8");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE,
    S_FLUSH_HI,
    S_FLUSH_LO,
    S_SELECT,
    S_SETUP,
    S_SCK_HI,
    S_SCK_LO,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              bit_q, bit_d;
  logic                    gap_half_q, gap_half_d;
  logic [15:0]             shreg_q, shreg_d;
  logic [NUM_REGS-1:0]     mask_q, mask_d;
  logic [8*NUM_REGS-1:0]   data_q, data_d;
  logic [2:0]              cur_addr_q, cur_addr_d;
  logic                    ncs_q, ncs_d;
  logic                    sclk_q, sclk_d;
  logic                    copi_q, copi_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [2:0]              sel_idx;
  logic [7:0]              sel_byte;
  logic                    half_done;
  logic                    frame_d;

  // Find the lowest pending register and its data byte.
  // The loop runs downward, so the lowest set bit is the last one written.
  always_comb begin
    sel_idx  = '0;
    sel_byte = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_idx  = 3'(i);
        sel_byte = data_q[8*i +: 8];
      end
    end
  end

  // Next-state logic: sequence flush pulse, frames and gaps, with half-period timing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    gap_half_d = gap_half_q;
    shreg_d    = shreg_q;
    mask_d     = mask_q;
    data_d     = data_q;
    cur_addr_d = cur_addr_q;
    half_done  = (cnt_q == HALF_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = cfg_data;
          mask_d  = wr_mask;
          cnt_d   = '0;
          state_d = (wr_mask != '0) ? S_FLUSH_HI : S_SELECT;
        end
      end

      S_FLUSH_HI: begin
        if (half_done) begin
          cnt_d   = '0;
          state_d = S_FLUSH_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FLUSH_LO: begin
        if (half_done) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SELECT: begin
        if (mask_q == '0) begin
          state_d = S_DONE;
        end else begin
          shreg_d    = {sel_byte, 4'b0000, sel_idx, 1'b1};
          cur_addr_d = sel_idx;
          mask_d     = mask_q & ~(NUM_REGS'(1) << sel_idx);
          bit_d      = '0;
          cnt_d      = '0;
          state_d    = S_SETUP;
        end
      end

      S_SETUP: begin
        if (half_done) begin
          cnt_d   = '0;
          state_d = S_SCK_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SCK_HI: begin
        if (half_done) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[15:1]};
          state_d = S_SCK_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SCK_LO: begin
        if (half_done) begin
          cnt_d = '0;
          if (bit_q == 4'd15) begin
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = S_SCK_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (half_done) begin
          cnt_d      = '0;
          gap_half_d = 1'b0;
          state_d    = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (!gap_half_q) begin
          if (half_done) begin
            cnt_d      = '0;
            gap_half_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (mask_q != '0 && cnt_q == GAP_SHORT_LAST) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end else if (half_done) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so each pin is registered and moves with its state.
  always_comb begin
    frame_d = (state_d == S_SETUP) || (state_d == S_SCK_HI) ||
              (state_d == S_SCK_LO) || (state_d == S_HOLD);
    ncs_d   = !frame_d;
    sclk_d  = (state_d == S_FLUSH_HI) || (state_d == S_SCK_HI);
    copi_d  = frame_d & shreg_d[0];
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers, with synchronous reset to the idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      gap_half_q <= 1'b0;
      shreg_q    <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      cur_addr_q <= '0;
      ncs_q      <= 1'b1;
      sclk_q     <= 1'b0;
      copi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      gap_half_q <= gap_half_d;
      shreg_q    <= shreg_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      cur_addr_q <= cur_addr_d;
      ncs_q      <= ncs_d;
      sclk_q     <= sclk_d;
      copi_q     <= copi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ncs      = ncs_q;
  assign sclk     = sclk_q;
  assign copi     = copi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cur_addr = cur_addr_q;

endmodule

// File: tb/tb_spi_config_sequencer.sv
// Testbench for spi_config_sequencer.
// Two instances are used: one at CLK_DIV=4 and one at CLK_DIV=8. Each has a
// negedge bus monitor acting as the SPI peripheral; the monitors capture frames
// and timing.
module tb_spi_config_sequencer;

  localparam int NR = 5;
  localparam int D4 = 4;
  localparam int D8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start8 = 1'b0;
  logic [NR-1:0] wr_mask = '0;
  logic [8*NR-1:0] cfg_data = '0;
  logic ncs, sclk, copi, busy, done;
  logic [2:0] cur_addr;
  logic ncs8, sclk8, copi8, busy8, done8;
  logic [2:0] cur_addr8;

  int checks = 0;
  int failures = 0;

  // Monitor state for the CLK_DIV=4 instance
  logic prev_sclk = 1'b0, prev_ncs = 1'b1, prev_copi = 1'b0;
  int flush_rises, data_rises, rx_cnt, ncs_low_cnt, gap_cnt, since_rise, done_delay;
  int copi_glitch, sclk_high_cycles, ncs_low_cycles;
  logic [15:0] rx_bits;
  logic [15:0] frame_bits_q[$];
  int frame_cnt_q[$], frame_len_q[$], frame_addr_q[$], gap_q[$];
  logic [7:0] periph_regs [0:7];

  // Monitor state for the CLK_DIV=8 instance
  logic p8_sclk = 1'b0, p8_ncs = 1'b1, p8_copi = 1'b0;
  int rx8_cnt, ncs8_low_cnt, ncs8_len, hi_run, lo_run, hi_min, hi_max, lo_min, lo_max;
  int glitch8, lo_before_rise, frames8;
  logic [15:0] rx8_bits, last8_bits;

  always #5 clk = ~clk;

  spi_config_sequencer #(.CLK_DIV(D4), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_mask(wr_mask), .cfg_data(cfg_data),
    .ncs(ncs), .sclk(sclk), .copi(copi), .busy(busy), .done(done), .cur_addr(cur_addr)
  );

  spi_config_sequencer #(.CLK_DIV(D8), .NUM_REGS(NR)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .wr_mask(wr_mask), .cfg_data(cfg_data),
    .ncs(ncs8), .sclk(sclk8), .copi(copi8), .busy(busy8), .done(done8), .cur_addr(cur_addr8)
  );

  // Peripheral model and bus monitor for the CLK_DIV=4 instance
  always @(negedge clk) begin
    logic [6:0] a;
    if (sclk && !prev_sclk) begin
      if (ncs) flush_rises++;
      else begin
        if (rx_cnt < 16) rx_bits[rx_cnt] = copi;
        rx_cnt++;
        data_rises++;
      end
    end
    if (sclk && prev_sclk && copi !== prev_copi) copi_glitch++;
    if (sclk) sclk_high_cycles++;
    if (!ncs) begin
      ncs_low_cycles++;
      ncs_low_cnt++;
    end
    if (ncs && !prev_ncs) begin
      frame_bits_q.push_back(rx_bits);
      frame_cnt_q.push_back(rx_cnt);
      frame_len_q.push_back(ncs_low_cnt);
      frame_addr_q.push_back(int'(cur_addr));
      a = rx_bits[7:1];
      if (rx_cnt == 16 && rx_bits[0] && a < 7'd8) periph_regs[a[2:0]] = rx_bits[15:8];
      rx_cnt = 0;
      ncs_low_cnt = 0;
      since_rise = 1;
      gap_cnt = 1;
    end else begin
      since_rise++;
      if (ncs) gap_cnt++;
    end
    if (!ncs && prev_ncs && frame_bits_q.size() > 0) gap_q.push_back(gap_cnt);
    if (done) done_delay = since_rise;
    prev_sclk = sclk;
    prev_ncs = ncs;
    prev_copi = copi;
  end

  // Phase-length and frame monitor for the CLK_DIV=8 instance
  always @(negedge clk) begin
    if (!ncs8) ncs8_low_cnt++;
    if (ncs8 && !p8_ncs) begin
      ncs8_len = ncs8_low_cnt;
      lo_before_rise = lo_run;
      last8_bits = rx8_bits;
      frames8++;
      rx8_cnt = 0;
      ncs8_low_cnt = 0;
    end
    if (sclk8 && !p8_sclk) begin
      if (!ncs8) begin
        if (rx8_cnt > 0) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        if (rx8_cnt < 16) rx8_bits[rx8_cnt] = copi8;
        rx8_cnt++;
      end
      hi_run = 1;
    end else if (sclk8) hi_run++;
    if (!sclk8 && p8_sclk) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      lo_run = 1;
    end else if (!sclk8) lo_run++;
    if (sclk8 && p8_sclk && copi8 !== p8_copi) glitch8++;
    p8_sclk = sclk8;
    p8_ncs = ncs8;
    p8_copi = copi8;
  end

  // Expected frame straight from the frame format: R/W, address LSB first, data LSB first
  function automatic logic [15:0] exp_frame(input int addr, input logic [7:0] d);
    logic [15:0] f;
    f[0] = 1'b1;
    for (int k = 1; k < 8; k++) f[k] = ((addr >> (k - 1)) & 1) != 0;
    for (int k = 0; k < 8; k++) f[8 + k] = d[k];
    return f;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    flush_rises = 0; data_rises = 0; rx_cnt = 0; ncs_low_cnt = 0; gap_cnt = 0;
    since_rise = 0; done_delay = -1; copi_glitch = 0; sclk_high_cycles = 0; ncs_low_cycles = 0;
    frame_bits_q.delete(); frame_cnt_q.delete(); frame_len_q.delete();
    frame_addr_q.delete(); gap_q.delete();
    for (int i = 0; i < 8; i++) periph_regs[i] = 'x;
  endtask

  task automatic clear_monitor8();
    rx8_cnt = 0; ncs8_low_cnt = 0; ncs8_len = -1; hi_run = 0; lo_run = 0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0; glitch8 = 0;
    lo_before_rise = -1; frames8 = 0; last8_bits = 'x;
  endtask

  task automatic pulse_start(input logic [NR-1:0] m, input logic [39:0] d, input bit use8);
    step();
    wr_mask = m;
    cfg_data = d;
    if (use8) start8 = 1'b1;
    else start = 1'b1;
    step();
    start = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic wait_done(input bit use8, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if ((use8 ? done8 : done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  function automatic logic [39:0] rand_image();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (ncs !== 1'b1) begin failures++; $display("[TB] FAIL reset_ncs got=%b exp=1", ncs); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("[TB] FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (copi !== 1'b0) begin failures++; $display("[TB] FAIL reset_copi got=%b exp=0", copi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (cur_addr !== 3'd0) begin failures++; $display("[TB] FAIL reset_cur_addr got=%0d exp=0", cur_addr); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    logic [39:0] d;
    bit ok;
    clear_monitor();
    d = rand_image();
    d[7:0] = 8'hA5;
    pulse_start(5'b00001, d, 1'b0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL single_timeout got=no_done exp=done"); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_at_done got=%b exp=1", busy); end
    checks++; if (done_delay != 2*D4 + 1) begin failures++; $display("[TB] FAIL single_done_after_gap got=%0d exp=%0d", done_delay, 2*D4 + 1); end
    checks++; if (flush_rises != 1) begin failures++; $display("[TB] FAIL single_flush got=%0d exp=1", flush_rises); end
    checks++; if (frame_bits_q.size() != 1) begin failures++; $display("[TB] FAIL single_frames got=%0d exp=1", frame_bits_q.size()); end
    if (frame_bits_q.size() >= 1) begin
      checks++; if (frame_bits_q[0] !== 16'b1010_0101_0000_0001) begin failures++; $display("[TB] FAIL single_bits got=%b exp=%b", frame_bits_q[0], 16'b1010_0101_0000_0001); end
      checks++; if (frame_len_q[0] != 34*D4) begin failures++; $display("[TB] FAIL single_ncs_low got=%0d exp=%0d", frame_len_q[0], 34*D4); end
      checks++; if (frame_cnt_q[0] != 16) begin failures++; $display("[TB] FAIL single_rises got=%0d exp=16", frame_cnt_q[0]); end
    end
    checks++; if (periph_regs[0] !== 8'hA5) begin failures++; $display("[TB] FAIL single_periph got=%h exp=a5", periph_regs[0]); end
    checks++; if (copi_glitch != 0) begin failures++; $display("[TB] FAIL single_copi_glitch got=%0d exp=0", copi_glitch); end
    checks++; if (cur_addr !== 3'd0) begin failures++; $display("[TB] FAIL single_cur_addr got=%0d exp=0", cur_addr); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL single_after_done got=%b%b exp=00", done, busy); end
  endtask

  task automatic test_multi_write();
    logic [39:0] d;
    bit ok;
    clear_monitor();
    d = rand_image();
    d[23:16] = 8'h3C;
    d[39:32] = 8'h80;
    pulse_start(5'b10100, d, 1'b0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL multi_timeout got=no_done exp=done"); end
    checks++; if (frame_addr_q.size() != 2) begin failures++; $display("[TB] FAIL multi_frames got=%0d exp=2", frame_addr_q.size()); end
    if (frame_addr_q.size() >= 2) begin
      checks++; if (frame_addr_q[0] != 2 || frame_addr_q[1] != 4) begin failures++; $display("[TB] FAIL multi_addr got=%0d,%0d exp=2,4", frame_addr_q[0], frame_addr_q[1]); end
    end
    checks++; if (gap_q.size() != 1) begin failures++; $display("[TB] FAIL multi_gap_count got=%0d exp=1", gap_q.size()); end
    if (gap_q.size() >= 1) begin
      checks++; if (gap_q[0] != 2*D4) begin failures++; $display("[TB] FAIL multi_gap got=%0d exp=%0d", gap_q[0], 2*D4); end
    end
    checks++; if (periph_regs[4] !== 8'h80) begin failures++; $display("[TB] FAIL multi_pwm_duty got=%h exp=80", periph_regs[4]); end
    checks++; if (periph_regs[2] !== 8'h3C) begin failures++; $display("[TB] FAIL multi_reg2 got=%h exp=3c", periph_regs[2]); end
    checks++; if (data_rises != 32 || flush_rises != 1) begin failures++; $display("[TB] FAIL multi_rises got=%0d+%0d exp=32+1", data_rises, flush_rises); end
    checks++; if (cur_addr !== 3'd4) begin failures++; $display("[TB] FAIL multi_cur_addr got=%0d exp=4", cur_addr); end
  endtask

  task automatic test_empty_mask();
    clear_monitor();
    pulse_start(5'b00000, rand_image(), 1'b0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("[TB] FAIL empty_first got=busy%b,done%b exp=busy1,done0", busy, done); end
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL empty_done got=%b exp=1", done); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL empty_idle got=busy%b,done%b exp=busy0,done0", busy, done); end
    checks++; if (ncs_low_cycles != 0 || sclk_high_cycles != 0) begin failures++; $display("[TB] FAIL empty_bus got=ncs_low%0d,sclk_hi%0d exp=0,0", ncs_low_cycles, sclk_high_cycles); end
  endtask

  task automatic test_busy_ignore();
    logic [NR-1:0] m1;
    logic [39:0] d1;
    int exp_addr[$];
    int nframes;
    bit ok;
    clear_monitor();
    m1 = NR'($urandom_range(1, 31)) | 5'b10001;
    d1 = rand_image();
    for (int i = 0; i < NR; i++) if (m1[i]) exp_addr.push_back(i);
    pulse_start(m1, d1, 1'b0);
    repeat (60) step();
    pulse_start(5'b01110, ~d1, 1'b0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL busy_ign_timeout got=no_done exp=done"); end
    checks++; if (frame_bits_q.size() != exp_addr.size()) begin failures++; $display("[TB] FAIL busy_ign_frames got=%0d exp=%0d", frame_bits_q.size(), exp_addr.size()); end
    for (int f = 0; f < exp_addr.size() && f < frame_bits_q.size(); f++) begin
      checks++;
      if (frame_bits_q[f] !== exp_frame(exp_addr[f], d1[8*exp_addr[f] +: 8])) begin
        failures++;
        $display("[TB] FAIL busy_ign_bits[%0d] got=%b exp=%b", f, frame_bits_q[f], exp_frame(exp_addr[f], d1[8*exp_addr[f] +: 8]));
      end
    end
    nframes = frame_bits_q.size();
    repeat (40) step();
    checks++; if (busy !== 1'b0 || frame_bits_q.size() != nframes) begin failures++; $display("[TB] FAIL busy_ign_rerun got=busy%b,frames%0d exp=busy0,frames%0d", busy, frame_bits_q.size(), nframes); end
  endtask

  task automatic test_reset_midframe();
    logic [39:0] d;
    logic [7:0] b2;
    int h0;
    bit found, ok;
    clear_monitor();
    d = rand_image();
    pulse_start(5'b00001, d, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (sclk === 1'b1 && ncs === 1'b0 && rx_cnt == 10) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL rst_mid_reach got=not_found exp=bit9_high"); end
    rst = 1'b1;
    step();
    checks++; if (ncs !== 1'b1 || sclk !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_bus got=ncs%b,sclk%b exp=ncs1,sclk0", ncs, sclk); end
    checks++; if (copi !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_state got=copi%b,busy%b exp=copi0,busy0", copi, busy); end
    rst = 1'b0;
    h0 = sclk_high_cycles;
    repeat (20) step();
    checks++; if (sclk_high_cycles != h0) begin failures++; $display("[TB] FAIL rst_mid_quiet got=%0d exp=%0d", sclk_high_cycles, h0); end
    clear_monitor();
    b2 = ~d[7:0];
    d[7:0] = b2;
    pulse_start(5'b00001, d, 1'b0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL rst_mid_timeout got=no_done exp=done"); end
    checks++; if (flush_rises != 1 || frame_bits_q.size() != 1) begin failures++; $display("[TB] FAIL rst_mid_rerun got=flush%0d,frames%0d exp=1,1", flush_rises, frame_bits_q.size()); end
    if (frame_bits_q.size() >= 1) begin
      checks++; if (frame_bits_q[0] !== exp_frame(0, b2)) begin failures++; $display("[TB] FAIL rst_mid_bits got=%b exp=%b", frame_bits_q[0], exp_frame(0, b2)); end
    end
    checks++; if (periph_regs[0] !== b2) begin failures++; $display("[TB] FAIL rst_mid_periph got=%h exp=%h", periph_regs[0], b2); end
  endtask

  task automatic test_random();
    logic [NR-1:0] m;
    logic [39:0] d;
    int exp_addr[$];
    bit ok;
    for (int it = 0; it < 4; it++) begin
      clear_monitor();
      exp_addr.delete();
      m = NR'($urandom_range(1, 31));
      d = rand_image();
      for (int i = 0; i < NR; i++) if (m[i]) exp_addr.push_back(i);
      pulse_start(m, d, 1'b0);
      wait_done(1'b0, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rand%0d_timeout got=no_done exp=done", it); end
      checks++; if (frame_bits_q.size() != exp_addr.size()) begin failures++; $display("[TB] FAIL rand%0d_frames got=%0d exp=%0d", it, frame_bits_q.size(), exp_addr.size()); end
      checks++; if (flush_rises != 1 || data_rises != 16*exp_addr.size()) begin failures++; $display("[TB] FAIL rand%0d_rises got=%0d+%0d exp=%0d+1", it, data_rises, flush_rises, 16*exp_addr.size()); end
      for (int f = 0; f < exp_addr.size() && f < frame_bits_q.size(); f++) begin
        checks++;
        if (frame_bits_q[f] !== exp_frame(exp_addr[f], d[8*exp_addr[f] +: 8]) || frame_len_q[f] != 34*D4 || frame_addr_q[f] != exp_addr[f]) begin
          failures++;
          $display("[TB] FAIL rand%0d_frame%0d got=%b/len%0d/addr%0d exp=%b/len%0d/addr%0d", it, f, frame_bits_q[f], frame_len_q[f], frame_addr_q[f], exp_frame(exp_addr[f], d[8*exp_addr[f] +: 8]), 34*D4, exp_addr[f]);
        end
        checks++;
        if (periph_regs[exp_addr[f]] !== d[8*exp_addr[f] +: 8]) begin
          failures++;
          $display("[TB] FAIL rand%0d_periph%0d got=%h exp=%h", it, exp_addr[f], periph_regs[exp_addr[f]], d[8*exp_addr[f] +: 8]);
        end
      end
      foreach (gap_q[g]) begin
        checks++; if (gap_q[g] != 2*D4) begin failures++; $display("[TB] FAIL rand%0d_gap%0d got=%0d exp=%0d", it, g, gap_q[g], 2*D4); end
      end
      checks++; if (copi_glitch != 0) begin failures++; $display("[TB] FAIL rand%0d_copi_glitch got=%0d exp=0", it, copi_glitch); end
      step();
    end
  endtask

  task automatic test_clk_div8();
    logic [39:0] d;
    int a;
    bit ok;
    clear_monitor8();
    a = $urandom_range(0, NR - 1);
    d = rand_image();
    pulse_start(NR'(1) << a, d, 1'b1);
    wait_done(1'b1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL div8_timeout got=no_done exp=done"); end
    checks++; if (frames8 != 1 || ncs8_len != 34*D8) begin failures++; $display("[TB] FAIL div8_ncs_low got=frames%0d,len%0d exp=1,%0d", frames8, ncs8_len, 34*D8); end
    checks++; if (hi_min != D8 || hi_max != D8) begin failures++; $display("[TB] FAIL div8_high_phase got=%0d..%0d exp=%0d", hi_min, hi_max, D8); end
    checks++; if (lo_min != D8 || lo_max != D8) begin failures++; $display("[TB] FAIL div8_low_phase got=%0d..%0d exp=%0d", lo_min, lo_max, D8); end
    checks++; if (glitch8 != 0) begin failures++; $display("[TB] FAIL div8_copi_glitch got=%0d exp=0", glitch8); end
    checks++; if (lo_before_rise < D8) begin failures++; $display("[TB] FAIL div8_ncs_rise_low got=%0d exp>=%0d", lo_before_rise, D8); end
    checks++; if (last8_bits !== exp_frame(a, d[8*a +: 8])) begin failures++; $display("[TB] FAIL div8_bits got=%b exp=%b", last8_bits, exp_frame(a, d[8*a +: 8])); end
  endtask

  initial begin
    clear_monitor();
    clear_monitor8();
    $display("[TB] start");
    test_reset();
    test_single_write();
    test_multi_write();
    test_empty_mask();
    test_busy_ignore();
    test_reset_midframe();
    test_random();
    test_clk_div8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
